// File: rtl/booth_radix4_mult_if.sv
// Handshake and operand/result bundle for the radix-4 Booth multiplier.
// The requester drives start, mode and operands; the multiplier returns
// busy, the one-cycle done pulse and the 2N-bit product.
interface booth_radix4_mult_if #(
  parameter int N = 8
);
  logic           start;
  logic           signed_mode;
  logic [N-1:0]   m;
  logic [N-1:0]   q;
  logic           busy;
  logic           done;
  logic [2*N-1:0] P;

  modport master (
    output start, signed_mode, m, q,
    input  busy, done, P
  );

  modport slave (
    input  start, signed_mode, m, q,
    output busy, done, P
  );
endinterface

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 (modified) Booth multiplier.
// Operands are extended to W = N+2 bits so that both signed and unsigned
// values are representable as W-bit two's complement with an even digit
// count. One Booth digit is retired per cycle: ITER = W/2 steps, so done
// rises ITER cycles after the accepting edge. The product register P only
// changes on the completion edge or on reset.
module booth_radix4_mult #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  booth_radix4_mult_if.slave  bus
);
  localparam int W    = N + 2;
  localparam int ITER = W / 2;
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [2*W-1:0] r_mcand;     // multiplicand, sign-extended to 2W, pre-scaled by 4^i
  logic [W:0]     r_mplr;      // {q_ext, 1'b0}, shifted right one digit per step
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_p;
  logic [W-1:0]   w_m_ext;
  logic [W-1:0]   w_q_ext;
  logic [2*W-1:0] w_pp;
  logic [2*W-1:0] w_acc_next;
  logic           w_accept;
  logic           w_last;

  // A new request is taken in IDLE and also in DONE for back-to-back use.
  assign w_accept = bus.start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  // Two extra bits make unsigned N-bit values non-negative in W-bit form.
  assign w_m_ext = {{2{bus.signed_mode & bus.m[N-1]}}, bus.m};
  assign w_q_ext = {{2{bus.signed_mode & bus.q[N-1]}}, bus.q};

  // Booth digit selection from the low triplet of the multiplier register;
  // negation is plain two's complement modulo 2^(2W).
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_pp = '0;
    case (r_mplr[2:0])
      3'b001, 3'b010: w_pp = r_mcand;
      3'b011:         w_pp = r_mcand << 1;
      3'b100:         w_pp = -(r_mcand << 1);
      3'b101, 3'b110: w_pp = -r_mcand;
      default:        w_pp = '0;
    endcase
  end

  assign w_acc_next = r_acc + w_pp;

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    w_state_next = bus.start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register; reset wins over any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Datapath: load on accept, one Booth step per RUN cycle, capture P at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else if (w_accept) begin
      r_mcand <= {{W{w_m_ext[W-1]}}, w_m_ext};
      r_mplr  <= {w_q_ext, 1'b0};
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_next;
      r_mcand <= r_mcand << 2;
      r_mplr  <= r_mplr >> 2;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) r_p <= w_acc_next[2*N-1:0];
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.P    = r_p;

  // Operands and mode must be known whenever a request is actually taken.
  a_known_on_accept: assert property (@(posedge clk) disable iff (rst)
    w_accept |-> !$isunknown({bus.signed_mode, bus.m, bus.q}));

endmodule

// File: doc/booth_radix4_mult.md
Name: booth_radix4_mult

Overview:
Parametrised sequential radix-4 (modified) Booth multiplier. It is the successor to the radix-2 Booth multiplier and has these changes:
- explicit start/busy/done handshake instead of operand load during reset;
- runtime signed/unsigned mode;
- two multiplier bits retired per cycle, so latency is N/2+1 cycles instead of N.

It sits in the arithmetic datapath, alongside the existing multipliers, as a drop-in multi-cycle multiply unit.

Parameters:
N, 8, operand width in bits; must be even and >= 4.
W, N+2, internal extended operand width (derived, not overridable); gives an exact unsigned range and an even digit count.
ITER, W/2, number of radix-4 iterations (derived; 5 for N=8).

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
signed_mode  input  1  1: m and q are two's complement; 0: unsigned. Sampled with start.
m  input  N  multiplicand; sampled with start.
q  input  N  multiplier; sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when P becomes valid.
P  output  2N  product; held stable from done until the next accepted start completes.

Behaviour:
- Reset: synchronous, active-high. Takes priority over everything, including mid-operation.
  - State goes to IDLE.
  - busy=0, done=0, P=0; all internal registers cleared.
  - An aborted operation produces no done.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge latches the operands, clears the accumulator and the iteration counter, and moves to RUN. busy=1 after that edge.
  - RUN: one radix-4 step per edge; the counter goes 0..ITER-1. On the edge where counter=ITER-1:
    - P <= low 2N bits of the final accumulator;
    - done <= 1, busy <= 0;
    - state goes to DONE.
  - DONE: lasts exactly one cycle; done=1 during it.
    - start=1 is accepted here exactly as in IDLE (back-to-back operation): RUN, busy=1, done=0 next cycle.
    - Otherwise the state goes to IDLE.
- start while in RUN is ignored. No queuing. Operands and mode remain those latched at acceptance.
- Latency: start sampled at edge E0; done is high in the cycle following edge E0+ITER (E5 for N=8).
  - Throughput: one result every ITER+1 cycles when start is held high.
- Operand extension to W bits at acceptance:
  - signed_mode=1: sign-extend both operands.
  - signed_mode=0: zero-extend both operands.
- Radix-4 recoding: the multiplier register holds {q_ext, 1'b0}. Each step examines the triplet at bits [2i+1:2i-1].
  - 000/111 -> 0
  - 001/010 -> +M
  - 011 -> +2M
  - 100 -> -2M
  - 101/110 -> -M
- Partial product arithmetic:
  - Accumulator width is 2W.
  - The selected partial product is sign-extended to 2W and shifted left by 2i.
  - -X is formed as two's complement.
  - Overflow cannot occur.
- Result: the full product always fits in 2N bits for both modes, so P is exact. This includes the signed -2^(N-1) * -2^(N-1) case and the unsigned (2^N-1)^2 case.
- P is unchanged in every state except on the completion edge and on reset.
- X or Z on inputs is a verification error only when start is sampled.

Test Plan:
1. Signed: rst 1 cycle, then start with m=8'd125, q=8'd38, signed_mode=1 -> busy for 5 cycles, done pulse 1 cycle, P=16'h128E (4750).
2. Signed negative: m=8'hA1 (-95), q=8'd38, signed_mode=1 -> P=16'hF1E6 (-3610). Same operands with signed_mode=0 (161*38) -> P=16'h17E6 (6118).
3. Extremes:
   - signed m=q=8'h80 -> P=16'h4000;
   - unsigned m=q=8'hFF -> P=16'hFE01;
   - signed m=8'h7F, q=8'h80 -> P=16'hC080;
   - m=0, any q -> P=0.
4. Handshake:
   - start held high continuously -> results every 6 cycles; done never coincides with busy.
   - start pulsed during RUN with different operands -> ignored; the original product is delivered and P is held after done.
5. Reset mid-op: assert rst during the 3rd RUN cycle -> the next cycle has busy=0, done=0, P=0, with no done pulse later. A fresh start then completes correctly.
6. Parameter sweep: N=4, 6, 16 against a reference model, with random operands and both modes (e.g. N=16 signed 16'h8000*16'h8000 -> 32'h40000000). Latency must equal N/2+1.
